// File: rtl/divider_cfg_ctrl_pkg.sv
// Shared definitions for the N_divider reconfiguration sequencer:
// divisor width default, state encodings and reset divisor.
package divider_cfg_ctrl_pkg;

    localparam int SIZE_DEF      = 4;
    localparam int DEFAULT_N_DEF = 1;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        QUIESCE = 3'd2,
        RST     = 3'd3,
        SETTLE  = 3'd4
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/divider_cfg_ctrl_cycle_timer.sv
// Down-counter shared by the reset and settle phases: load, decrement, zero flag.
// Saturates at zero so it never wraps; every phase entry reloads it.
module divider_cfg_ctrl_cycle_timer #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         ref_clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - W'(1);
    end

    always_ff @(posedge ref_clk) begin
        if (reset) count_q <= RST_VAL;
        else       count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/divider_cfg_ctrl.sv
// Reconfiguration sequencer for N_divider: accepts a new divisor, drops enable,
// pulses the divider reset with the new N on the bus, settles, then re-enables.
module divider_cfg_ctrl
    import divider_cfg_ctrl_pkg::*;
#(
    parameter int SIZE          = SIZE_DEF,
    parameter int DEFAULT_N     = DEFAULT_N_DEF,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            ref_clk,
    input  logic            reset,
    input  logic            run,
    input  logic            req_valid,
    input  logic [SIZE-1:0] req_n,
    output logic            req_ready,
    output logic            div_enable,
    output logic            div_reset,
    output logic [SIZE-1:0] div_n,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int              CW         = $clog2(max2(RST_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CW-1:0]   RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]   SET_LOAD   = CW'(SETTLE_CYCLES - 1);
    localparam logic [SIZE-1:0] DEF_N      = SIZE'(DEFAULT_N);

    state_e          state_q, state_d;
    logic [SIZE-1:0] div_n_q, div_n_d, pend_n_q, pend_n_d;
    logic            div_reset_q, div_reset_d, div_enable_q, div_enable_d;
    logic            req_ready_q, req_ready_d, busy_q, busy_d;
    logic            done_q, done_d, err_q, err_d;
    // Distinguishes a requested sequence from the power-up one, which ends without done.
    logic            from_req_q, from_req_d;
    logic            t_load, t_dec, t_zero;
    logic [CW-1:0]   t_val;

    divider_cfg_ctrl_cycle_timer #(.W(CW), .RST_VAL(RST_LOAD)) u_timer (
        .ref_clk  (ref_clk),
        .reset    (reset),
        .load     (t_load),
        .dec      (t_dec),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_d      = state_q;
        div_n_d      = div_n_q;
        pend_n_d     = pend_n_q;
        div_reset_d  = div_reset_q;
        div_enable_d = div_enable_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        from_req_d   = from_req_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        t_load       = 1'b0;
        t_dec        = 1'b0;
        t_val        = RST_LOAD;

        case (state_q)
            INIT, RST: begin
                t_dec = 1'b1;
                if (t_zero) begin
                    state_d     = SETTLE;
                    div_reset_d = 1'b0;
                    t_load      = 1'b1;
                    t_val       = SET_LOAD;
                end
            end
            SETTLE: begin
                t_dec = 1'b1;
                if (t_zero) begin
                    state_d      = IDLE;
                    div_enable_d = run;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = from_req_q;
                    from_req_d   = 1'b0;
                end
            end
            IDLE: begin
                div_reset_d  = 1'b0;
                req_ready_d  = 1'b1;
                busy_d       = 1'b0;
                div_enable_d = run;
                if (req_valid && req_ready_q) begin
                    if (req_n == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = QUIESCE;
                        pend_n_d     = req_n;
                        div_enable_d = 1'b0;
                        req_ready_d  = 1'b0;
                        busy_d       = 1'b1;
                        from_req_d   = 1'b1;
                    end
                end
            end
            QUIESCE: begin
                state_d     = RST;
                div_n_d     = pend_n_q;
                div_reset_d = 1'b1;
                t_load      = 1'b1;
                t_val       = RST_LOAD;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q      <= INIT;
            div_n_q      <= DEF_N;
            pend_n_q     <= DEF_N;
            div_reset_q  <= 1'b1;
            div_enable_q <= 1'b0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            from_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_n_q      <= div_n_d;
            pend_n_q     <= pend_n_d;
            div_reset_q  <= div_reset_d;
            div_enable_q <= div_enable_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            from_req_q   <= from_req_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign div_enable = div_enable_q;
    assign div_reset  = div_reset_q;
    assign div_n      = div_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_divider_cfg_ctrl.sv
// Directed bench for divider_cfg_ctrl: cycle-exact checks after each edge plus a
// scoreboard of expected done/err pulses popped by a negedge monitor.
module tb_divider_cfg_ctrl;

    localparam int SIZE = 4;

    typedef struct {
        logic       is_err;
        logic [3:0] n;
    } ev_t;

    logic            ref_clk = 1'b0;
    logic            reset, run, req_valid;
    logic [SIZE-1:0] req_n;
    logic            req_ready, div_enable, div_reset, busy, done, err;
    logic [SIZE-1:0] div_n;

    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    divider_cfg_ctrl dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .run        (run),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .div_enable (div_enable),
        .div_reset  (div_reset),
        .div_n      (div_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic push(input logic is_err, input logic [3:0] n);
        ev_t e;
        e.is_err = is_err;
        e.n      = n;
        sb.push_back(e);
    endtask

    // Pulses popped from the scoreboard; any unexpected pulse is a failure.
    always @(negedge ref_clk) begin
        if (reset === 1'b0) chk("never_both", {31'd0, div_reset & div_enable}, 32'd0);
        if (done === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("sb_done", {31'd0, done}, {31'd0, ~e.is_err});
                chk("sb_err",  {31'd0, err},  {31'd0, e.is_err});
                chk("sb_div_n", {28'd0, div_n}, {28'd0, e.n});
            end
        end
    end

    initial begin
        reset = 1'b1; run = 1'b1; req_valid = 1'b0; req_n = '0;

        // 1: power-up sequence
        tick();
        chk("rst_div_reset", div_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_enable", div_enable, 0);
        chk("rst_div_n", div_n, 1);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();
        chk("init_div_reset2", div_reset, 1);
        tick();
        chk("init_settle_reset", div_reset, 0);
        chk("init_settle_enable", div_enable, 0);
        chk("init_settle_busy", busy, 1);
        tick();
        chk("init_idle_enable", div_enable, 1);
        chk("init_idle_ready", req_ready, 1);
        chk("init_idle_busy", busy, 0);
        chk("init_idle_div_n", div_n, 1);
        chk("init_no_done", done, 0);

        // 2: req_n=3
        req_valid = 1'b1; req_n = 4'd3; push(1'b0, 4'd3);
        tick();
        chk("s2_enable_low", div_enable, 0);
        chk("s2_ready_low", req_ready, 0);
        chk("s2_busy", busy, 1);
        req_valid = 1'b0;
        tick();
        chk("s2_div_n", div_n, 3);
        chk("s2_div_reset1", div_reset, 1);
        tick();
        chk("s2_div_reset2", div_reset, 1);
        tick();
        chk("s2_settle_reset", div_reset, 0);
        chk("s2_settle_enable", div_enable, 0);
        chk("s2_settle_done", done, 0);
        tick();
        chk("s2_done", done, 1);
        chk("s2_enable", div_enable, 1);
        chk("s2_ready", req_ready, 1);

        // 3: req_n=0 rejected
        req_valid = 1'b1; req_n = 4'd0; push(1'b1, 4'd3);
        tick();
        chk("s3_err", err, 1);
        chk("s3_busy", busy, 0);
        chk("s3_div_n", div_n, 3);
        chk("s3_enable", div_enable, 1);
        req_valid = 1'b0;
        tick();
        chk("s3_err_clear", err, 0);

        // 4: req_n=4 then req_n=5 held while busy
        req_valid = 1'b1; req_n = 4'd4; push(1'b0, 4'd4);
        tick();
        req_n = 4'd5; push(1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_ready_busy", req_ready, 0);
        end
        tick();
        chk("s4_done1", done, 1);
        chk("s4_ready_idle", req_ready, 1);
        chk("s4_div_n1", div_n, 4);
        tick();
        chk("s4_accept2", req_ready, 0);
        chk("s4_busy2", busy, 1);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("s4_done2", done, 1);
        chk("s4_div_n2", div_n, 5);

        // 5: run dropped during RST
        req_valid = 1'b1; req_n = 4'd2; push(1'b0, 4'd2);
        tick();
        req_valid = 1'b0;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        chk("s5_done", done, 1);
        chk("s5_enable_off", div_enable, 0);
        chk("s5_div_n", div_n, 2);
        run = 1'b1;
        tick();
        chk("s5_enable_on", div_enable, 1);

        // 6: reset during SETTLE of req_n=6
        req_valid = 1'b1; req_n = 4'd6;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("s6_in_settle", div_n, 6);
        reset = 1'b1;
        tick();
        chk("s6_div_n", div_n, 1);
        chk("s6_div_reset", div_reset, 1);
        chk("s6_busy", busy, 1);
        chk("s6_no_done", done, 0);
        chk("s6_enable", div_enable, 0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("s6_recover_enable", div_enable, 1);
        chk("s6_recover_ready", req_ready, 1);
        chk("s6_recover_div_n", div_n, 1);
        tick();
        chk("s6_no_late_done", done, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
